// File: rtl/frogger_state_ctrl.sv
// frogger_state_ctrl: top-level game sequencer for Frogger.
// Owns the game state machine, the life counter, the score and the
// per-state frame timer. Every output is driven straight from a register.
module frogger_state_ctrl #(
  parameter int c_LIVES          = 3,
  parameter int c_GOAL_ROW       = 0,
  parameter int c_RESPAWN_FRAMES = 60,
  parameter int c_WIN_FRAMES     = 120,
  parameter int c_SCORE_MAX      = 99
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Frame_Tick,
  input  logic       i_Game_Start,
  input  logic       i_Collided,
  input  logic       i_Drowned,
  input  logic [5:0] i_Frogger_Y,
  output logic [2:0] o_State,
  output logic       o_Game_Active,
  output logic       o_Respawn,
  output logic       o_Objects_Reset,
  output logic [1:0] o_Lives,
  output logic [6:0] o_Score
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEANUP   = 3'd1,
    RUNNING   = 3'd2,
    DYING     = 3'd3,
    P1_WINS   = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  state_t     r_state;
  logic       r_start_q;
  logic [1:0] r_lives;
  logic [6:0] r_score;
  logic [7:0] r_frame_cnt;
  logic       r_game_active;
  logic       r_respawn;
  logic       r_objects_reset;

  logic w_start_edge;
  logic w_hazard;
  logic w_goal;

  // A held button produces one edge; it must be released before the next.
  assign w_start_edge = i_Game_Start & ~r_start_q;
  assign w_hazard     = i_Collided | i_Drowned;
  assign w_goal       = (i_Frogger_Y == 6'(c_GOAL_ROW));

  // Remember last cycle's start button level for edge detection.
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      r_start_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples the
      // pre-edge values of the others, regardless of statement order.
      r_start_q <= i_Game_Start;
    end
  end

  // Game FSM with lives, score, frame timer and registered status outputs.
  // Each transition sets the outputs that belong to the state being entered.
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      r_state         <= IDLE;
      r_lives         <= 2'(c_LIVES);
      r_score         <= 7'd0;
      r_frame_cnt     <= 8'd0;
      r_game_active   <= 1'b0;
      r_respawn       <= 1'b0;
      r_objects_reset <= 1'b0;
    end else begin
      // Pulsed outputs default low; only an entry into their state raises them.
      r_respawn       <= 1'b0;
      r_objects_reset <= 1'b0;
      r_game_active   <= 1'b0;

      case (r_state)
        IDLE, GAME_OVER: begin
          if (w_start_edge) begin
            r_lives         <= 2'(c_LIVES);
            r_score         <= 7'd0;
            r_state         <= CLEANUP;
            r_objects_reset <= 1'b1;
          end
        end

        CLEANUP: begin
          r_state       <= RUNNING;
          r_game_active <= 1'b1;
          r_respawn     <= 1'b1;
        end

        RUNNING: begin
          r_game_active <= 1'b1;
          // The respawn cycle is a grace cycle: the frog has not moved yet.
          if (!r_respawn) begin
            if (w_hazard) begin
              r_game_active <= 1'b0;
              if (r_lives > 2'd1) begin
                r_lives     <= r_lives - 2'd1;
                r_frame_cnt <= 8'(c_RESPAWN_FRAMES);
                r_state     <= DYING;
              end else begin
                r_lives <= 2'd0;
                r_state <= GAME_OVER;
              end
            end else if (w_goal) begin
              r_game_active <= 1'b0;
              if (r_score < 7'(c_SCORE_MAX)) begin
                r_score <= r_score + 7'd1;
              end
              r_frame_cnt <= 8'(c_WIN_FRAMES);
              r_state     <= P1_WINS;
            end
          end
        end

        DYING: begin
          if (i_Frame_Tick) begin
            r_frame_cnt <= r_frame_cnt - 8'd1;
            if (r_frame_cnt == 8'd1) begin
              r_state       <= RUNNING;
              r_game_active <= 1'b1;
              r_respawn     <= 1'b1;
            end
          end
        end

        P1_WINS: begin
          if (i_Frame_Tick) begin
            r_frame_cnt <= r_frame_cnt - 8'd1;
            if (r_frame_cnt == 8'd1) begin
              r_state         <= CLEANUP;
              r_objects_reset <= 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_State         = r_state;
  assign o_Game_Active   = r_game_active;
  assign o_Respawn       = r_respawn;
  assign o_Objects_Reset = r_objects_reset;
  assign o_Lives         = r_lives;
  assign o_Score         = r_score;

endmodule

// File: doc/frogger_state_ctrl.md
# frogger_state_ctrl

Top-level game sequencer for the Frogger design. It owns the game state machine, the life counter and the score. It gates frog movement through `o_Game_Active` and commands respawn and object reset. It sits between the VGA/game datapath (frog control, car/log controllers, collision checker) and the score display, replacing the free-running `w_Game_Active = 1` tie-off.

## Interface
Clocking and reset are fixed: one clock; reset is asynchronous and active-low.

Parameters:
- `c_LIVES`, default 3: lives loaded at game start; range 1..3.
- `c_GOAL_ROW`, default 0: frog tile row that counts as reaching home.
- `c_RESPAWN_FRAMES`, default 60: frames spent in DYING; range 1..255.
- `c_WIN_FRAMES`, default 120: frames spent in P1_WINS; range 1..255.
- `c_SCORE_MAX`, default 99: score saturation value; must be ≤ 127.

Ports:
- `i_Clk`, in, 1: system clock.
- `i_Rst_N`, in, 1: asynchronous active-low reset.
- `i_Frame_Tick`, in, 1: single-cycle pulse once per video frame.
- `i_Game_Start`, in, 1: start button, already debounced and synchronous.
- `i_Collided`, in, 1: frog/car collision, level.
- `i_Drowned`, in, 1: frog on water with no log, level.
- `i_Frogger_Y`, in, 6: frog tile row.
- `o_State`, out, 3: current state encoding.
- `o_Game_Active`, out, 1: frog movement enable.
- `o_Respawn`, out, 1: pulse; frog controller reloads start position.
- `o_Objects_Reset`, out, 1: pulse; car/log controllers reload initial positions.
- `o_Lives`, out, 2: remaining lives.
- `o_Score`, out, 7: score to the 7-segment driver.

## Operation
- State encodings: IDLE=0, CLEANUP=1, RUNNING=2, DYING=3, P1_WINS=4, GAME_OVER=5. Codes 6 and 7 return to IDLE on the next clock.
- Start edge: `i_Game_Start` & ~(`i_Game_Start` registered the previous cycle).
- Hazard: `i_Collided` | `i_Drowned`.
- IDLE, on a start edge:
  - Load lives = `c_LIVES` and score = 0.
  - Next state CLEANUP.
- GAME_OVER, on a start edge: same as IDLE (reload lives and score, go to CLEANUP).
- CLEANUP lasts exactly 1 cycle, then goes to RUNNING. It leaves lives and score unchanged.
- RUNNING, with priority hazard > goal:
  - Hazard, lives > 1: lives−1, load the frame counter with `c_RESPAWN_FRAMES`, go to DYING.
  - Hazard, lives = 1: lives = 0, go to GAME_OVER.
  - Else, if `i_Frogger_Y` == `c_GOAL_ROW`: score = min(score+1, `c_SCORE_MAX`), load the frame counter with `c_WIN_FRAMES`, go to P1_WINS.
  - In the first RUNNING cycle (while `o_Respawn` = 1), hazard and goal are ignored.
- DYING: the counter decrements on each `i_Frame_Tick`. On a tick with counter = 1, go to RUNNING. Objects are not reset.
- P1_WINS: the counter decrements on each `i_Frame_Tick`. On a tick with counter = 1, go to CLEANUP.
- A start edge is ignored in CLEANUP, RUNNING, DYING and P1_WINS.
- Hazard and goal inputs are ignored in every state except RUNNING.
- Frame counter: 8 bits, internal.

## Timing
- All outputs are registered. Reset values:
  - `o_State` = IDLE (0)
  - `o_Game_Active` = 0
  - `o_Respawn` = 0
  - `o_Objects_Reset` = 0
  - `o_Lives` = `c_LIVES`
  - `o_Score` = 0
  - frame counter = 0
- `o_Game_Active` = 1 exactly while the state is RUNNING.
- `o_Objects_Reset` = 1 exactly while the state is CLEANUP (a 1-cycle pulse).
- `o_Respawn` = 1 for exactly the first cycle in RUNNING after any entry (from CLEANUP or from DYING).
- Latency:
  - Start edge at cycle N: state = CLEANUP at N+1, RUNNING at N+2.
  - Hazard sampled at cycle N in RUNNING: `o_Lives` and `o_State` update at N+1.
- A frame tick in the same cycle as entry to DYING or P1_WINS is not counted. Counting begins the cycle after entry.
- Exit timing: DYING lasts exactly `c_RESPAWN_FRAMES` ticks and P1_WINS exactly `c_WIN_FRAMES` ticks. The exit occurs the cycle after the final tick.
- Hazard and goal in the same cycle: the hazard wins and the score is unchanged.
- Score at `c_SCORE_MAX`: a goal still enters P1_WINS, but the score holds.
- Asserting `i_Rst_N` low in any state forces all reset values immediately, independent of the clock. On release, the block waits in IDLE for a start edge.
- A held start button gives exactly one start edge. The button must be released and re-pressed before another start edge can occur.

## Test plan
- Reset, then start held 5 cycles: CLEANUP for 1 cycle with `o_Objects_Reset` = 1, then RUNNING with `o_Respawn` = 1 for 1 cycle. `o_Lives` = 3, `o_Score` = 0, and only one game start occurs.
- In RUNNING, 1-cycle `i_Collided`: `o_Lives` 3→2, state DYING. After exactly 60 frame ticks, RUNNING with `o_Respawn` pulse and no `o_Objects_Reset`. Collisions during DYING do not change `o_Lives`.
- Three hazards across respawns: 3→2→1→0, state GAME_OVER, `o_Game_Active` = 0. A start edge then reloads `o_Lives` = 3, `o_Score` = 0 and goes to CLEANUP.
- `i_Frogger_Y` = 0 with `o_Score` preset to 98 via repeated wins: 98→99, P1_WINS for 120 ticks, then CLEANUP and RUNNING. The next win keeps `o_Score` = 99.
- `i_Drowned` and `i_Frogger_Y` = 0 in the same cycle: `o_Lives` decrements, `o_Score` is unchanged, state DYING. Hazard asserted during the `o_Respawn` cycle: ignored.
- `i_Rst_N` pulsed low mid-DYING (counter = 30): outputs return to reset values immediately. After release, the state stays IDLE until a start edge.
